// File: rtl/wpa2_addr_sequencer.sv
// wpa2_addr_sequencer: Avalon-MM slave that drives the address bus of the WPA2 core,
// either directly from software (MANUAL register) or as an autonomous burst
// BASE, BASE+1, ... of COUNT addresses, each handed over on a valid/ready handshake.
// Optional feature macro: WPA2_SEQ_IRQ_EN adds a registered completion interrupt (irq)
// and the IRQ_EN bit (CTRL bit 8).
module wpa2_addr_sequencer #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [ADDR_W-1:0] out_port,
   output logic              addr_valid,
   input  logic              addr_ready
`ifdef WPA2_SEQ_IRQ_EN
   ,
   output logic              irq
`endif
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e            state_q, state_d;
   // out_q doubles as the burst's current address while running
   logic [ADDR_W-1:0] out_q, out_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              done_q, done_d;
   logic              irq_en_q, irq_en_d;
   logic              irq_q, irq_d;

   logic wr, ctrl_wr, start, abort, done_clr, start_ok, finish;
   logic unused_wd;

   assign unused_wd = ^writedata;

   // Decode the write strobe and control bits
   always_comb begin
      wr       = chipselect & ~write_n;
      ctrl_wr  = wr & (address == 2'd0);
      start    = ctrl_wr & writedata[0];
      abort    = ctrl_wr & writedata[1];
      done_clr = ctrl_wr & writedata[2];
   end

   // Next-state logic: register writes, burst sequencing, DONE/IRQ bookkeeping
   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      rem_d    = rem_q;
      base_d   = base_q;
      count_d  = count_q;
      done_d   = done_q;
      irq_en_d = irq_en_q;
      irq_d    = irq_q;
      start_ok = 1'b0;
      finish   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               // START wins over a simultaneous ABORT while idle
               state_d  = StRun;
               out_d    = base_q;
               rem_d    = count_q;
               start_ok = 1'b1;
            end else if (wr) begin
               case (address)
                  2'd1:    base_d  = writedata[ADDR_W-1:0];
                  2'd2:    count_d = writedata[CNT_W-1:0];
                  2'd3:    out_d   = writedata[ADDR_W-1:0];
                  default: ;
               endcase
            end
         end
         StRun: begin
            // ABORT beats a coincident handshake: no increment, no DONE
            if (abort) begin
               state_d = StIdle;
            end else if (addr_ready) begin
               if (rem_q == CNT_W'(1)) begin
                  state_d = StIdle;
                  finish  = 1'b1;
               end else begin
                  out_d = out_q + ADDR_W'(1);
                  rem_d = rem_q - CNT_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Set beats clear when both happen on one edge
      if (done_clr || start_ok) done_d = 1'b0;
      if (finish)               done_d = 1'b1;

`ifdef WPA2_SEQ_IRQ_EN
      if (ctrl_wr) irq_en_d = writedata[8];
      irq_d = done_q & irq_en_q & ~done_clr & ~start_ok;
`else
      irq_en_d = 1'b0;
      irq_d    = 1'b0;
`endif
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         out_q    <= '0;
         rem_q    <= '0;
         base_q   <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         rem_q    <= rem_d;
         base_q   <= base_d;
         count_q  <= count_d;
         done_q   <= done_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   // Outputs and zero-latency register readback
   always_comb begin
      out_port   = out_q;
      addr_valid = (state_q == StRun);
      readdata   = '0;
      unique case (address)
         2'd0: begin
            readdata[0] = (state_q == StRun);
            readdata[1] = done_q;
`ifdef WPA2_SEQ_IRQ_EN
            readdata[8] = irq_en_q;
`endif
         end
         2'd1: readdata[ADDR_W-1:0] = base_q;
         2'd2: readdata[CNT_W-1:0]  = count_q;
         2'd3: readdata[ADDR_W-1:0] = out_q;
         default: ;
      endcase
   end

`ifdef WPA2_SEQ_IRQ_EN
   assign irq = irq_q;
`else
   logic unused_irq;
   assign unused_irq = irq_q ^ irq_en_q;
`endif

endmodule
